video_out: RTL and testbench

//  Parametrised video back-end between the game core (pong) and board pins.

---
 rtl/video_pkg.sv | 14 +
 rtl/video_out_ce_gen.sv | 31 +++
 rtl/video_out.sv | 90 +++++++++
 tb/tb_video_out.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants and helpers for the video back-end.
// Holds the sync mode encodings, the default channel width and the channel slice helper.
// Contains no logic, so it has no latency and no backpressure.
package video_pkg;
  localparam logic MODE_CSYNC = 1'b0;
  localparam logic MODE_SEP   = 1'b1;
  localparam int   CW_DEF     = 2;
  localparam int   NUM_CH     = 3;

  // The rgb bus is {r,g,b}, so channel 0 (red) is in the top slice.
  function automatic int ch_lsb(input int ch, input int cw);
    return (NUM_CH - 1 - ch) * cw;
  endfunction
endpackage

// File: rtl/video_out_ce_gen.sv
// Generates the core clock-enable: a free-running divide-by-DIV counter.
// ce is registered and is high for the clock where count == DIV-1.
// The counter is free-running and has no backpressure.
module video_out_ce_gen #(
  parameter int DIV = 6
) (
  input  logic clock,
  input  logic reset,
  output logic ce
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = (count == LAST) ? '0 : count + CNT_W'(1);
  end

  // ce is registered from the next count so that it lines up with count == LAST.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      ce    <= 1'b0;
    end else begin
      count <= count_nxt;
      ce    <= (count_nxt == LAST);
    end
  end
endmodule

// File: rtl/video_out.sv
// Video back-end: samples core sync/pixel on ce, counts lines/frames, drives registered pins.
// Latency is 2 clocks from ce assertion to the pins; VIDEO_SCANLINE_EN halves odd-line colour.
// There is no backpressure: the core is paced only by ce.
module video_out
  import video_pkg::*;
#(
  parameter int DIV    = 6,
  parameter int CW     = CW_DEF,
  parameter int LINE_W = 10,
  parameter bit SYNC_N = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [NUM_CH*CW-1:0] fg,
  input  logic [NUM_CH*CW-1:0] bg,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 pixel_in,
  output logic                 ce,
  output logic [1:0]           sync,
  output logic [NUM_CH*CW-1:0] rgb,
  output logic [LINE_W-1:0]    line,
  output logic [7:0]           frame
);
  localparam logic [1:0] SYNC_IDLE = {2{SYNC_N}};

  logic h1, v1, p1;
  logic h_rise, v_rise;
  logic [1:0] sync_d;
  logic [NUM_CH*CW-1:0] col, rgb_d;

  video_out_ce_gen #(.DIV(DIV)) u_ce_gen (
    .clock (clock),
    .reset (reset),
    .ce    (ce)
  );

  assign h_rise = hsync_in & ~h1;
  assign v_rise = vsync_in & ~v1;

  // Stage 1 and the counters advance only on ce; vsync takes priority over hsync.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h1    <= 1'b0;
      v1    <= 1'b0;
      p1    <= 1'b0;
      line  <= '0;
      frame <= '0;
    end else if (ce) begin
      h1 <= hsync_in;
      v1 <= vsync_in;
      p1 <= pixel_in;
      if (v_rise) begin
        line  <= '0;
        frame <= frame + 8'd1;
      end else if (h_rise && (line != '1)) begin
        line <= line + LINE_W'(1);
      end
    end
  end

  always_comb begin
    case (mode)
      MODE_CSYNC: sync_d = {1'b1, ~(h1 ^ v1)};
      MODE_SEP:   sync_d = {~v1, ~h1};
      default:    sync_d = 2'b11;
    endcase
    sync_d = sync_d ^ {2{~SYNC_N}};
    col = p1 ? fg : bg;
`ifdef VIDEO_SCANLINE_EN
    if (line[0]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        col[ch_lsb(i, CW) +: CW] = col[ch_lsb(i, CW) +: CW] >> 1;
      end
    end
`endif
    rgb_d = (h1 | v1) ? '0 : col;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= SYNC_IDLE;
      rgb  <= '0;
    end else begin
      sync <= sync_d;
      rgb  <= rgb_d;
    end
  end
endmodule

// File: tb/tb_video_out.sv
// Directed bench for video_out (DIV=6 instance plus a DIV=1 instance for the ce check).
module tb_video_out;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic [5:0] fg = 6'h3F;
  logic [5:0] bg = 6'h00;
  logic       hsync_in = 1'b0, vsync_in = 1'b0, pixel_in = 1'b0;
  logic       ce, ce1;
  logic [1:0] sync, sync1;
  logic [5:0] rgb, rgb1;
  logic [9:0] line, line1;
  logic [7:0] frame, frame1;

  int checks = 0;
  int errors = 0;
  int exp_frame;
  int n;

`ifdef VIDEO_SCANLINE_EN
  localparam logic [5:0] ODD_FG = 6'h15;
`else
  localparam logic [5:0] ODD_FG = 6'h3F;
`endif

  always #5 clock = ~clock;

  video_out u_dut (
    .clock(clock), .reset(reset), .mode(mode), .fg(fg), .bg(bg),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_in(pixel_in),
    .ce(ce), .sync(sync), .rgb(rgb), .line(line), .frame(frame)
  );

  video_out #(.DIV(1)) u_dut1 (
    .clock(clock), .reset(reset), .mode(mode), .fg(fg), .bg(bg),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_in(pixel_in),
    .ce(ce1), .sync(sync1), .rgb(rgb1), .line(line1), .frame(frame1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs, wait for the next ce, return just after the sampling edge.
  task automatic step(input logic h, input logic v, input logic p);
    int k;
    hsync_in = h;
    vsync_in = v;
    pixel_in = p;
    k = 0;
    while (ce !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (ce !== 1'b1) chk("ce_timeout", 32'(ce), 32'd1);
    @(posedge clock);
    #1;
  endtask

  // Sample on ce, then wait for the pin stage and land on a negedge.
  task automatic do_ce(input logic h, input logic v, input logic p);
    step(h, v, p);
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_ce1", 32'(ce1), 32'd0);
    chk("rst_sync", 32'(sync), 32'h3);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_line", 32'(line), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    chk("rst_dut1", {sync1, rgb1, line1, frame1}, {2'b11, 6'h0, 10'h0, 8'h0});
    reset = 1'b0;

    for (int k = 1; k <= 18; k++) begin
      @(negedge clock);
      chk($sformatf("ce_div6_%0d", k), 32'(ce), 32'((k % 6) == 5));
      chk($sformatf("ce_div1_%0d", k), 32'(ce1), 32'd1);
    end

    // composite sync
    do_ce(1'b1, 1'b0, 1'b0);
    chk("csync_h", 32'(sync), 32'h2);
    chk("line_h1", 32'(line), 32'd1);
    do_ce(1'b1, 1'b1, 1'b0);
    chk("csync_hv", 32'(sync), 32'h3);
    chk("line_v", 32'(line), 32'd0);
    chk("frame_v", 32'(frame), 32'd1);

    // separate sync and colour
    mode = 1'b1;
    do_ce(1'b0, 1'b0, 1'b1);
    chk("sep_rgb_fg", 32'(rgb), 32'h3F);
    chk("sep_sync_idle", 32'(sync), 32'h3);
    do_ce(1'b1, 1'b0, 1'b1);
    chk("sep_rgb_blank", 32'(rgb), 32'h0);
    chk("sep_sync_h", 32'(sync), 32'h2);
    chk("line_1", 32'(line), 32'd1);
    do_ce(1'b0, 1'b0, 1'b1);
    chk("scan_odd", 32'(rgb), 32'(ODD_FG));
    do_ce(1'b1, 1'b0, 1'b1);
    chk("line_2", 32'(line), 32'd2);
    do_ce(1'b0, 1'b0, 1'b1);
    chk("scan_even", 32'(rgb), 32'h3F);

    // vsync in separate mode, then mode change takes effect next clock
    do_ce(1'b0, 1'b1, 1'b0);
    chk("sep_sync_v", 32'(sync), 32'h1);
    chk("frame_2", 32'(frame), 32'd2);
    mode = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("mode_switch", 32'(sync), 32'h2);

    bg = 6'h2A;
    do_ce(1'b0, 1'b0, 1'b0);
    chk("rgb_bg", 32'(rgb), 32'h2A);

    // three hsyncs, then vsync coincident with the fourth
    for (int i = 1; i <= 3; i++) begin
      do_ce(1'b1, 1'b0, 1'b0);
      chk($sformatf("line_seq_%0d", i), 32'(line), 32'(i));
      do_ce(1'b0, 1'b0, 1'b0);
    end
    do_ce(1'b1, 1'b1, 1'b0);
    chk("line_hv_wins", 32'(line), 32'd0);
    chk("frame_3", 32'(frame), 32'd3);

    // run the frame counter up to 255 and across the wrap
    exp_frame = 3;
    while (exp_frame < 255) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      exp_frame++;
    end
    chk("frame_255", 32'(frame), 32'd255);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("frame_wrap", 32'(frame), 32'd0);

    // reset mid-line, asserted while ce is high
    fg = 6'h3F;
    do_ce(1'b0, 1'b0, 1'b1);
    chk("pre_rst_rgb", 32'(rgb), 32'h3F);
    n = 0;
    while (ce !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("pre_rst_ce", 32'(ce), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ce", 32'(ce), 32'd0);
    chk("mid_rst_rgb", 32'(rgb), 32'h0);
    chk("mid_rst_sync", 32'(sync), 32'h3);
    chk("mid_rst_frame", 32'(frame), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (ce !== 1'b1 && n < 20);
    chk("ce_after_rst", 32'(n), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
